layer_compositor: RTL and testbench

//  Per-pixel compositor between vga_controller and the 12-pin RGB output. Layers the

---
 rtl/layer_compositor_if.sv | 41 ++++
 rtl/layer_compositor.sv | 151 +++++++++++++++
 tb/tb_layer_compositor.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/layer_compositor_if.sv
// Pixel/scene bus between the video timing side and the layer compositor.
// The master drives pixel coordinates, scene objects and colours; the slave
// (compositor) returns the composited colour, the collision flag and the
// frame-start pulse.
interface layer_compositor_if #(
    parameter int NUM_BARS = 4,
    parameter int COORD_W  = 10,
    parameter int COLOR_W  = 12
);
    logic                          video_on;
    logic [COORD_W-1:0]            x;
    logic [COORD_W-1:0]            y;
    logic [NUM_BARS*COORD_W-1:0]   bar_x;
    logic [NUM_BARS*COORD_W-1:0]   gap_y;
    logic [NUM_BARS-1:0]           bar_en;
    logic [COORD_W-1:0]            sprite_x;
    logic [COORD_W-1:0]            sprite_y;
    logic [4:0]                    sprite_w;
    logic [4:0]                    sprite_h;
    logic [COLOR_W-1:0]            sprite_color;
    logic [COLOR_W-1:0]            bar_color;
    logic [COLOR_W-1:0]            sky_color;
    logic                          hit_clr;
    logic [COLOR_W-1:0]            rgb;
    logic                          hit;
    logic                          frame_start;

    modport master (
        output video_on, x, y, bar_x, gap_y, bar_en,
               sprite_x, sprite_y, sprite_w, sprite_h,
               sprite_color, bar_color, sky_color, hit_clr,
        input  rgb, hit, frame_start
    );

    modport slave (
        input  video_on, x, y, bar_x, gap_y, bar_en,
               sprite_x, sprite_y, sprite_w, sprite_h,
               sprite_color, bar_color, sky_color, hit_clr,
        output rgb, hit, frame_start
    );
endinterface

// File: rtl/layer_compositor.sv
// Two-stage per-pixel compositor: sprite over bar obstacles over sky.
// Stage 1 registers the per-object hit tests (plus video_on, the origin flag
// and the colours of that pixel); stage 2 selects the colour, updates the
// sticky sprite/bar collision flag and emits the frame-start pulse.
module layer_compositor #(
    parameter int NUM_BARS = 4,
    parameter int COORD_W  = 10,
    parameter int COLOR_W  = 12,
    parameter int BAR_W    = 40,
    parameter int GAP_H    = 24
) (
    input  logic               clk_100MHz,
    input  logic               reset_n,
    layer_compositor_if.slave  bus
);
    // One guard bit so all comparisons and clamps are done without wrap.
    localparam int CW = COORD_W + 1;
    localparam logic [CW-1:0] BAR_W_C  = CW'(BAR_W);
    localparam logic [CW-1:0] HALF_GAP = CW'(GAP_H / 2);
    localparam logic [CW-1:0] CW_MAX   = '1;

    logic [CW-1:0]       x_ext;
    logic [CW-1:0]       y_ext;
    logic [NUM_BARS-1:0] in_bar_raw;
    logic                in_sprite_raw;

    assign x_ext = {1'b0, bus.x};
    assign y_ext = {1'b0, bus.y};

    // Per-bar containment: horizontal span clamped at 0, gap window saturated.
    generate
        for (genvar gi = 0; gi < NUM_BARS; gi++) begin : g_bar
            logic [CW-1:0] bx;
            logic [CW-1:0] gy;
            logic [CW-1:0] lo;
            logic [CW-1:0] glo;
            logic [CW-1:0] ghi;
            logic [CW:0]   ghi_sum;

            assign bx      = {1'b0, bus.bar_x[gi*COORD_W +: COORD_W]};
            assign gy      = {1'b0, bus.gap_y[gi*COORD_W +: COORD_W]};
            assign lo      = (bx < BAR_W_C) ? '0 : (bx - BAR_W_C);
            assign glo     = (gy < HALF_GAP) ? '0 : (gy - HALF_GAP);
            assign ghi_sum = {1'b0, gy} + {1'b0, HALF_GAP};
            assign ghi     = ghi_sum[CW] ? CW_MAX : ghi_sum[CW-1:0];
            assign in_bar_raw[gi] = bus.bar_en[gi]
                                  && (x_ext >= lo) && (x_ext < bx)
                                  && !((y_ext >= glo) && (y_ext <= ghi));
        end
    endgenerate

    // Sprite box test on absolute distances from the sprite centre.
    logic [CW-1:0] sx_ext, sy_ext, dx, dy, half_w, half_h;
    assign sx_ext        = {1'b0, bus.sprite_x};
    assign sy_ext        = {1'b0, bus.sprite_y};
    assign dx            = (x_ext >= sx_ext) ? (x_ext - sx_ext) : (sx_ext - x_ext);
    assign dy            = (y_ext >= sy_ext) ? (y_ext - sy_ext) : (sy_ext - y_ext);
    assign half_w        = CW'(bus.sprite_w >> 1);
    assign half_h        = CW'(bus.sprite_h >> 1);
    assign in_sprite_raw = (dx <= half_w) && (dy <= half_h);

    // Stage 1 state
    logic [NUM_BARS-1:0] in_bar_d, in_bar_q;
    logic                in_sprite_d, in_sprite_q;
    logic                video_on_d, video_on_q;
    logic                origin_d, origin_q;
    logic [COLOR_W-1:0]  sprite_color_d, sprite_color_q;
    logic [COLOR_W-1:0]  bar_color_d, bar_color_q;
    logic [COLOR_W-1:0]  sky_color_d, sky_color_q;

    // Stage 1 next-state: capture hit tests and the colours of this pixel.
    always_comb begin
        in_bar_d       = in_bar_raw;
        in_sprite_d    = in_sprite_raw;
        video_on_d     = bus.video_on;
        origin_d       = (bus.x == '0) && (bus.y == '0);
        sprite_color_d = bus.sprite_color;
        bar_color_d    = bus.bar_color;
        sky_color_d    = bus.sky_color;
    end

    // Stage 1 registers.
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            in_bar_q       <= '0;
            in_sprite_q    <= 1'b0;
            video_on_q     <= 1'b0;
            origin_q       <= 1'b0;
            sprite_color_q <= '0;
            bar_color_q    <= '0;
            sky_color_q    <= '0;
        end else begin
            in_bar_q       <= in_bar_d;
            in_sprite_q    <= in_sprite_d;
            video_on_q     <= video_on_d;
            origin_q       <= origin_d;
            sprite_color_q <= sprite_color_d;
            bar_color_q    <= bar_color_d;
            sky_color_q    <= sky_color_d;
        end
    end

    // Stage 2 state
    logic [COLOR_W-1:0] rgb_d, rgb_q;
    logic               hit_d, hit_q;
    logic               frame_start_d, frame_start_q;
    logic               any_bar;
    logic               hit_set;

    assign any_bar = |in_bar_q;
    assign hit_set = video_on_q && in_sprite_q && any_bar;

    // Stage 2 next-state: layer priority, blanking, sticky hit (set beats clear).
    always_comb begin
        rgb_d         = '0;
        hit_d         = hit_q;
        frame_start_d = origin_q;
        if (video_on_q) begin
            if (in_sprite_q) begin
                rgb_d = sprite_color_q;
            end else if (any_bar) begin
                rgb_d = bar_color_q;
            end else begin
                rgb_d = sky_color_q;
            end
        end
        if (bus.hit_clr || origin_q) begin
            hit_d = 1'b0;
        end
        if (hit_set) begin
            hit_d = 1'b1;
        end
    end

    // Stage 2 registers.
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            rgb_q         <= '0;
            hit_q         <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            rgb_q         <= rgb_d;
            hit_q         <= hit_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign bus.rgb         = rgb_q;
    assign bus.hit         = hit_q;
    assign bus.frame_start = frame_start_q;
endmodule

// File: tb/tb_layer_compositor.sv
// Directed bench for layer_compositor with 8 bar channels.
module tb_layer_compositor;
    localparam int NB = 8;
    localparam int CW = 10;
    localparam int KW = 12;
    localparam logic [KW-1:0] SKY    = 12'h00F;
    localparam logic [KW-1:0] BAR    = 12'h0F0;
    localparam logic [KW-1:0] SPRITE = 12'hF00;

    logic clk_100MHz = 1'b0;
    logic reset_n    = 1'b0;
    int   checks     = 0;
    int   passes     = 0;

    always #5 clk_100MHz = ~clk_100MHz;

    layer_compositor_if #(.NUM_BARS(NB), .COORD_W(CW), .COLOR_W(KW)) bus ();

    layer_compositor #(
        .NUM_BARS(NB), .COORD_W(CW), .COLOR_W(KW), .BAR_W(40), .GAP_H(24)
    ) dut (
        .clk_100MHz (clk_100MHz),
        .reset_n    (reset_n),
        .bus        (bus)
    );

    task automatic set_bar(input int i, input int bx, input int gy, input bit en);
        bus.bar_x[i*CW +: CW] = bx[CW-1:0];
        bus.gap_y[i*CW +: CW] = gy[CW-1:0];
        bus.bar_en[i]         = en;
    endtask

    task automatic set_sprite(input int sx, input int sy, input int w, input int h);
        bus.sprite_x = sx[CW-1:0];
        bus.sprite_y = sy[CW-1:0];
        bus.sprite_w = w[4:0];
        bus.sprite_h = h[4:0];
    endtask

    // Present one pixel and wait until it has reached the output.
    task automatic show_pix(input int px, input int py, input bit vo);
        @(negedge clk_100MHz);
        bus.x        = px[CW-1:0];
        bus.y        = py[CW-1:0];
        bus.video_on = vo;
        @(posedge clk_100MHz);
        @(posedge clk_100MHz);
        #1;
    endtask

    task automatic clear_hit();
        @(negedge clk_100MHz);
        bus.video_on = 1'b0;
        bus.hit_clr  = 1'b1;
        repeat (3) @(negedge clk_100MHz);
        bus.hit_clr  = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        set_bar(0, 200, 240, 1'b1);
        bus.x = 10'd170; bus.y = 10'd100; bus.video_on = 1'b1;
        repeat (3) @(posedge clk_100MHz);
        #1;
        checks++;
        if (bus.rgb !== '0) $display("FAIL reset_rgb rgb=%h expected %h", bus.rgb, 12'h000);
        else passes++;
        checks++;
        if (bus.hit !== 1'b0) $display("FAIL reset_hit hit=%b expected 0", bus.hit);
        else passes++;
        checks++;
        if (bus.frame_start !== 1'b0) $display("FAIL reset_fs frame_start=%b expected 0", bus.frame_start);
        else passes++;
        @(negedge clk_100MHz);
        reset_n = 1'b1;
        @(posedge clk_100MHz); #1;
        checks++;
        if (bus.rgb !== '0) $display("FAIL release_early rgb=%h expected %h", bus.rgb, 12'h000);
        else passes++;
        @(posedge clk_100MHz); #1;
        checks++;
        if (bus.rgb !== BAR) $display("FAIL release_valid rgb=%h expected %h", bus.rgb, BAR);
        else passes++;
        // Mid-line reset: output drops without waiting for a clock edge.
        @(posedge clk_100MHz); #3;
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus.rgb !== '0) $display("FAIL midline_reset rgb=%h expected %h", bus.rgb, 12'h000);
        else passes++;
        @(negedge clk_100MHz);
        reset_n = 1'b1;
        @(posedge clk_100MHz); #1;
        checks++;
        if (bus.rgb !== '0) $display("FAIL midline_refill rgb=%h expected %h", bus.rgb, 12'h000);
        else passes++;
        @(posedge clk_100MHz); #1;
        checks++;
        if (bus.rgb !== BAR) $display("FAIL midline_valid rgb=%h expected %h", bus.rgb, BAR);
        else passes++;
    endtask

    task automatic test_bar_edges();
        int xs [8] = '{159, 160, 199, 200, 180, 180, 180, 180};
        int ys [8] = '{100, 100, 100, 100, 228, 252, 227, 253};
        logic [KW-1:0] exps [8] = '{SKY, BAR, BAR, SKY, SKY, SKY, BAR, BAR};
        set_bar(0, 200, 240, 1'b1);
        for (int k = 0; k < 8; k++) begin
            show_pix(xs[k], ys[k], 1'b1);
            checks++;
            if (bus.rgb !== exps[k])
                $display("FAIL bar_edge x=%0d y=%0d rgb=%h expected %h", xs[k], ys[k], bus.rgb, exps[k]);
            else passes++;
        end
    endtask

    task automatic test_clamp();
        int xs [5] = '{0, 19, 20, 1000, 1020};
        logic [KW-1:0] exps [5] = '{BAR, BAR, SKY, SKY, SKY};
        int gys [3] = '{0, 17, 18};
        logic [KW-1:0] gexps [3] = '{SKY, SKY, BAR};
        set_bar(0, 20, 500, 1'b1);
        for (int k = 0; k < 5; k++) begin
            show_pix(xs[k], 100, 1'b1);
            checks++;
            if (bus.rgb !== exps[k])
                $display("FAIL clamp_x x=%0d rgb=%h expected %h", xs[k], bus.rgb, exps[k]);
            else passes++;
        end
        set_bar(0, 20, 5, 1'b1);
        for (int k = 0; k < 3; k++) begin
            show_pix(10, gys[k], 1'b1);
            checks++;
            if (bus.rgb !== gexps[k])
                $display("FAIL clamp_gap y=%0d rgb=%h expected %h", gys[k], bus.rgb, gexps[k]);
            else passes++;
        end
    endtask

    task automatic test_priority();
        int xs [6] = '{180, 184, 185, 180, 180, 175};
        int ys [6] = '{100, 100, 100, 104, 105, 100};
        logic [KW-1:0] exps [6] = '{SPRITE, SPRITE, BAR, SPRITE, BAR, BAR};
        set_bar(0, 200, 240, 1'b1);
        set_sprite(180, 100, 8, 8);
        clear_hit();
        show_pix(180, 100, 1'b0);
        checks++;
        if (bus.rgb !== '0) $display("FAIL blank_rgb rgb=%h expected %h", bus.rgb, 12'h000);
        else passes++;
        checks++;
        if (bus.hit !== 1'b0) $display("FAIL blank_hit hit=%b expected 0", bus.hit);
        else passes++;
        for (int k = 0; k < 6; k++) begin
            show_pix(xs[k], ys[k], 1'b1);
            checks++;
            if (bus.rgb !== exps[k])
                $display("FAIL priority x=%0d y=%0d rgb=%h expected %h", xs[k], ys[k], bus.rgb, exps[k]);
            else passes++;
        end
    endtask

    task automatic test_collision();
        set_bar(0, 200, 240, 1'b1);
        set_sprite(180, 100, 8, 8);
        @(negedge clk_100MHz);
        bus.x = 10'd300; bus.y = 10'd100;
        clear_hit();
        @(posedge clk_100MHz); #1;
        checks++;
        if (bus.hit !== 1'b0) $display("FAIL hit_cleared hit=%b expected 0", bus.hit);
        else passes++;
        // Single overlapping active pixel.
        @(negedge clk_100MHz);
        bus.x = 10'd180; bus.y = 10'd100; bus.video_on = 1'b1;
        @(negedge clk_100MHz);
        bus.x = 10'd300;
        checks++;
        if (bus.hit !== 1'b0) $display("FAIL hit_early hit=%b expected 0", bus.hit);
        else passes++;
        @(posedge clk_100MHz); #1;
        checks++;
        if (bus.hit !== 1'b1) $display("FAIL hit_set hit=%b expected 1", bus.hit);
        else passes++;
        repeat (5) @(posedge clk_100MHz);
        #1;
        checks++;
        if (bus.hit !== 1'b1) $display("FAIL hit_held hit=%b expected 1", bus.hit);
        else passes++;
        @(negedge clk_100MHz);
        bus.hit_clr = 1'b1;
        @(posedge clk_100MHz); #1;
        checks++;
        if (bus.hit !== 1'b0) $display("FAIL hit_clr hit=%b expected 0", bus.hit);
        else passes++;
        @(negedge clk_100MHz);
        bus.hit_clr = 1'b0;
        // Overlap reaches stage 2 in the same cycle as hit_clr.
        @(negedge clk_100MHz);
        bus.x = 10'd180;
        @(negedge clk_100MHz);
        bus.x = 10'd300;
        bus.hit_clr = 1'b1;
        @(posedge clk_100MHz); #1;
        checks++;
        if (bus.hit !== 1'b1) $display("FAIL set_wins hit=%b expected 1", bus.hit);
        else passes++;
        @(negedge clk_100MHz);
        bus.hit_clr = 1'b0;
    endtask

    task automatic test_multi_bar();
        int xs [6] = '{330, 230, 730, 30, 300, 355};
        logic [KW-1:0] exps [6] = '{SKY, BAR, BAR, BAR, SKY, SKY};
        set_sprite(900, 900, 0, 0);
        for (int i = 0; i < NB; i++) set_bar(i, 50 + 100 * i, 500, i != 3);
        for (int k = 0; k < 6; k++) begin
            show_pix(xs[k], 100, 1'b1);
            checks++;
            if (bus.rgb !== exps[k])
                $display("FAIL multi_bar x=%0d rgb=%h expected %h", xs[k], bus.rgb, exps[k]);
            else passes++;
        end
        bus.bar_en[3] = 1'b1;
        show_pix(330, 100, 1'b1);
        checks++;
        if (bus.rgb !== BAR) $display("FAIL bar3_enabled rgb=%h expected %h", bus.rgb, BAR);
        else passes++;
    endtask

    task automatic test_frame_start();
        int pulses = 0;
        logic exp_fs;
        // Arm hit so the frame-start clear can be seen.
        set_sprite(230, 100, 8, 8);
        show_pix(230, 100, 1'b1);
        checks++;
        if (bus.hit !== 1'b1) $display("FAIL frame_hit_armed hit=%b expected 1", bus.hit);
        else passes++;
        set_sprite(900, 900, 0, 0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_100MHz);
            bus.video_on = 1'b0;
            bus.x = (k == 3) ? 10'd0 : 10'(k + 5);
            bus.y = (k == 3) ? 10'd0 : 10'd7;
            @(posedge clk_100MHz); #1;
            exp_fs = (k == 4);
            if (bus.frame_start === 1'b1) pulses++;
            checks++;
            if (bus.frame_start !== exp_fs)
                $display("FAIL frame_start cycle=%0d fs=%b expected %b", k, bus.frame_start, exp_fs);
            else passes++;
        end
        checks++;
        if (pulses !== 1) $display("FAIL frame_pulses count=%0d expected 1", pulses);
        else passes++;
        checks++;
        if (bus.hit !== 1'b0) $display("FAIL frame_clears_hit hit=%b expected 0", bus.hit);
        else passes++;
    endtask

    initial begin
        bus.video_on     = 1'b0;
        bus.x            = '0;
        bus.y            = '0;
        bus.bar_x        = '0;
        bus.gap_y        = '0;
        bus.bar_en       = '0;
        bus.hit_clr      = 1'b0;
        bus.sprite_color = SPRITE;
        bus.bar_color    = BAR;
        bus.sky_color    = SKY;
        set_sprite(900, 900, 0, 0);
        test_reset();
        test_bar_edges();
        test_clamp();
        test_priority();
        test_collision();
        test_multi_bar();
        test_frame_start();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
